// File: rtl/dmem_req_ctrl_pkg.sv
// Purpose : shared FSM state encoding and access-size constants for the data-side request controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package dmem_req_ctrl_pkg;

  // Controller state; the encoding is fixed so it can be probed in debug.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bus access sizes as driven on data_size.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Loads never assert byte strobes.
  localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// Purpose : bundles the MEM-stage request side and the SRAM-like data bus side of dmem_req_ctrl.
// Latency : n/a (wiring only).
// Backpressure: data_addr_ok / data_data_ok from the bus, stall_out back to the pipeline.
// Ports   : mem_* / flush / pipe_stall / stall_out / rdata_* face the pipeline;
//           data_* face the data bus. The slave modport is the controller's view.
interface dmem_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // MEM-stage side
  logic              mem_en;
  logic              mem_wen;
  logic [3:0]        mem_sel;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_except;
  logic              flush;
  logic              pipe_stall;
  logic              stall_out;
  logic [DATA_W-1:0] rdata_out;
  logic              rdata_valid;

  // Data bus side
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Pipeline plus bus environment: drives requests and bus responses.
  modport master (
    output mem_en, mem_wen, mem_sel, mem_size, mem_addr, mem_wdata,
    output mem_except, flush, pipe_stall,
    output data_addr_ok, data_data_ok, data_rdata,
    input  stall_out, rdata_out, rdata_valid,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata
  );

  // The request controller itself.
  modport slave (
    input  mem_en, mem_wen, mem_sel, mem_size, mem_addr, mem_wdata,
    input  mem_except, flush, pipe_stall,
    input  data_addr_ok, data_data_ok, data_rdata,
    output stall_out, rdata_out, rdata_valid,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata
  );

endinterface

// File: rtl/dmem_req_ctrl.sv
// Purpose : issues one MEM-stage load/store at a time on the req/addr_ok/data_ok bus and stalls the pipe until it completes.
// Latency : minimum 3 stall cycles per access (detect, addr_ok, data_ok); result valid in the 4th cycle.
// Backpressure: request fields held until data_addr_ok; stall_out held high until data_data_ok.
// Ports   : clk, rst (async active-high); mem_if (slave) carries the MEM-stage request,
//           flush/pipe_stall, stall_out, raw load data and the full data-bus handshake.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  dmem_req_ctrl_if.slave  mem_if
);

  state_e            r_state;
  state_e            w_next;
  logic              r_discard;
  logic              r_req;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [3:0]        r_wstrb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              w_start;
  logic              w_stall;

  // A new access only launches from IDLE; excepting or flushed instructions never reach the bus.
  always_comb begin
    w_start = (r_state == IDLE) & mem_if.mem_en & ~mem_if.mem_except & ~mem_if.flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    // Once an access is doomed (flush now or earlier) the pipeline must not be held for it.
    w_stall = w_start |
              (((r_state == REQ) | (r_state == WAIT)) & ~r_discard & ~mem_if.flush);
    case (r_state)
      IDLE: if (w_start) w_next = REQ;
      REQ:  if (mem_if.data_addr_ok) w_next = WAIT;
      WAIT: begin
        if (mem_if.data_data_ok)
          w_next = (r_discard | mem_if.flush) ? IDLE : DONE;
      end
      DONE: begin
        // mem_en is deliberately ignored here so the completed instruction is not reissued.
        if (mem_if.flush | ~mem_if.pipe_stall) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard     <= 1'b0;
      r_req         <= 1'b0;
      r_wr          <= 1'b0;
      r_size        <= SIZE_B;
      r_wstrb       <= STRB_NONE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_wr    <= mem_if.mem_wen;
            r_size  <= mem_if.mem_size;
            r_addr  <= mem_if.mem_addr;
            r_wdata <= mem_if.mem_wdata;
            r_wstrb <= mem_if.mem_wen ? mem_if.mem_sel : STRB_NONE;
          end
        end
        REQ: begin
          // An asserted req may not be withdrawn, so a flush only marks the response for dropping.
          if (mem_if.flush)        r_discard <= 1'b1;
          if (mem_if.data_addr_ok) r_req     <= 1'b0;
        end
        WAIT: begin
          if (mem_if.data_data_ok) begin
            if (r_discard | mem_if.flush) begin
              r_discard <= 1'b0;
            end else begin
              if (!r_wr) r_rdata <= mem_if.data_rdata;
              r_rdata_valid <= 1'b1;
            end
          end else if (mem_if.flush) begin
            r_discard <= 1'b1;
          end
        end
        DONE: begin
          if (mem_if.flush | ~mem_if.pipe_stall) r_rdata_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_if.stall_out   = w_stall;
  assign mem_if.rdata_out   = r_rdata;
  assign mem_if.rdata_valid = r_rdata_valid;
  assign mem_if.data_req    = r_req;
  assign mem_if.data_wr     = r_wr;
  assign mem_if.data_size   = r_size;
  assign mem_if.data_wstrb  = r_wstrb;
  assign mem_if.data_addr   = r_addr;
  assign mem_if.data_wdata  = r_wdata;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Purpose : directed self-checking bench for dmem_req_ctrl.
// Latency : inputs change 1 time unit after posedge; outputs are checked on the negedge.
// Backpressure: bench plays the data bus, choosing addr_ok/data_ok timing per scenario.
module tb_dmem_req_ctrl;
  import dmem_req_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dmem_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.mem_en       = 1'b0;
    bus_if.mem_wen      = 1'b0;
    bus_if.mem_sel      = 4'b0000;
    bus_if.mem_size     = 2'b00;
    bus_if.mem_addr     = 32'h0;
    bus_if.mem_wdata    = 32'h0;
    bus_if.mem_except   = 1'b0;
    bus_if.flush        = 1'b0;
    bus_if.pipe_stall   = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
  endtask

  task automatic start_load(input logic [31:0] addr);
    bus_if.mem_en   = 1'b1;
    bus_if.mem_wen  = 1'b0;
    bus_if.mem_sel  = 4'b1111;
    bus_if.mem_size = SIZE_W;
    bus_if.mem_addr = addr;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    total++;
    if ({bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb, bus_if.data_addr,
         bus_if.data_wdata, bus_if.rdata_out, bus_if.rdata_valid, bus_if.stall_out} !== 109'd0) begin
      bad++;
      $display("FAIL reset_outputs got req=%b wr=%b size=%b strb=%b addr=%h wdata=%h rdata=%h vld=%b stall=%b exp all zero",
               bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb, bus_if.data_addr,
               bus_if.data_wdata, bus_if.rdata_out, bus_if.rdata_valid, bus_if.stall_out);
    end
    total++;
    if (dut.r_state !== IDLE || dut.r_discard !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got state=%0d discard=%b exp 0/0", dut.r_state, dut.r_discard);
    end
    settle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_word();
    // cycle 0: detect
    start_load(32'h8000_0010);
    settle();
    total++;
    if (bus_if.stall_out !== 1'b1 || bus_if.data_req !== 1'b0) begin
      bad++; $display("FAIL lw_c0 got stall=%b req=%b exp 1/0", bus_if.stall_out, bus_if.data_req);
    end
    tick();
    // cycle 1: request on the bus, accepted immediately
    bus_if.data_addr_ok = 1'b1;
    settle();
    total++;
    if ({bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb, bus_if.data_addr, bus_if.stall_out}
        !== {1'b1, 1'b0, 2'b10, 4'b0000, 32'h8000_0010, 1'b1}) begin
      bad++; $display("FAIL lw_c1 got req=%b wr=%b size=%b strb=%b addr=%h stall=%b exp 1 0 10 0000 80000010 1",
                      bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb, bus_if.data_addr, bus_if.stall_out);
    end
    tick();
    // cycle 2: response
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'hDEAD_BEEF;
    settle();
    total++;
    if (bus_if.data_req !== 1'b0 || bus_if.stall_out !== 1'b1) begin
      bad++; $display("FAIL lw_c2 got req=%b stall=%b exp 0/1", bus_if.data_req, bus_if.stall_out);
    end
    tick();
    // cycle 3: result held, pipeline released
    bus_if.data_data_ok = 1'b0;
    bus_if.mem_en       = 1'b0;
    settle();
    total++;
    if (bus_if.stall_out !== 1'b0 || bus_if.rdata_valid !== 1'b1 || bus_if.rdata_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL lw_c3 got stall=%b vld=%b rdata=%h exp 0 1 deadbeef",
                      bus_if.stall_out, bus_if.rdata_valid, bus_if.rdata_out);
    end
    tick();
    settle();
    total++;
    if (bus_if.rdata_valid !== 1'b0 || dut.r_state !== IDLE) begin
      bad++; $display("FAIL lw_c4 got vld=%b state=%0d exp 0/IDLE", bus_if.rdata_valid, dut.r_state);
    end
    tick();
  endtask

  task automatic test_store_byte();
    int acc = 0;
    bus_if.mem_en    = 1'b1;
    bus_if.mem_wen   = 1'b1;
    bus_if.mem_sel   = 4'b1000;
    bus_if.mem_size  = SIZE_B;
    bus_if.mem_addr  = 32'h8000_0003;
    bus_if.mem_wdata = 32'h5A5A_5A5A;
    settle();
    tick();
    // three cycles without addr_ok: request must sit still
    for (int i = 0; i < 3; i++) begin
      settle();
      if (bus_if.data_req && bus_if.data_addr_ok) acc++;
      total++;
      if ({bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb, bus_if.data_addr, bus_if.data_wdata, bus_if.stall_out}
          !== {1'b1, 1'b1, 2'b00, 4'b1000, 32'h8000_0003, 32'h5A5A_5A5A, 1'b1}) begin
        bad++; $display("FAIL sb_hold%0d got req=%b wr=%b size=%b strb=%b addr=%h wdata=%h stall=%b exp 1 1 00 1000 80000003 5a5a5a5a 1",
                        i, bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb,
                        bus_if.data_addr, bus_if.data_wdata, bus_if.stall_out);
      end
      tick();
    end
    bus_if.data_addr_ok = 1'b1;
    settle();
    if (bus_if.data_req && bus_if.data_addr_ok) acc++;
    tick();
    bus_if.data_addr_ok = 1'b1;  // left high: must not be taken as a second acceptance
    settle();
    if (bus_if.data_req && bus_if.data_addr_ok) acc++;
    total++;
    if (bus_if.data_req !== 1'b0 || bus_if.stall_out !== 1'b1) begin
      bad++; $display("FAIL sb_wait got req=%b stall=%b exp 0/1", bus_if.data_req, bus_if.stall_out);
    end
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h7777_7777;  // write ack: data must be ignored
    settle();
    tick();
    bus_if.data_data_ok = 1'b0;
    bus_if.mem_en       = 1'b0;
    settle();
    total++;
    if (acc !== 1) begin
      bad++; $display("FAIL sb_accept_count got %0d exp 1", acc);
    end
    total++;
    if (bus_if.stall_out !== 1'b0 || bus_if.rdata_valid !== 1'b1 || bus_if.rdata_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL sb_done got stall=%b vld=%b rdata=%h exp 0 1 deadbeef",
                      bus_if.stall_out, bus_if.rdata_valid, bus_if.rdata_out);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_exception();
    int seen_req = 0;
    int seen_stall = 0;
    start_load(32'h8000_0001);
    bus_if.mem_except = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (bus_if.data_req) seen_req++;
      if (bus_if.stall_out) seen_stall++;
      tick();
    end
    // flush in IDLE blocks issue too
    bus_if.mem_except = 1'b0;
    bus_if.flush      = 1'b1;
    settle();
    if (bus_if.stall_out) seen_stall++;
    tick();
    idle_inputs();
    settle();
    if (bus_if.data_req) seen_req++;
    total++;
    if (seen_req !== 0 || seen_stall !== 0) begin
      bad++; $display("FAIL except_no_issue got req_cycles=%0d stall_cycles=%0d exp 0/0", seen_req, seen_stall);
    end
    tick();
  endtask

  task automatic test_flush_wait();
    start_load(32'h8000_0030);
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.flush        = 1'b1;
    settle();
    total++;
    if (bus_if.stall_out !== 1'b0) begin
      bad++; $display("FAIL fw_flush_cycle got stall=%b exp 0", bus_if.stall_out);
    end
    tick();
    bus_if.flush        = 1'b0;
    bus_if.mem_en       = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h1234_5678;
    settle();
    total++;
    if (bus_if.stall_out !== 1'b0 || bus_if.data_req !== 1'b0) begin
      bad++; $display("FAIL fw_discard got stall=%b req=%b exp 0/0", bus_if.stall_out, bus_if.data_req);
    end
    tick();
    idle_inputs();
    settle();
    total++;
    if (bus_if.rdata_valid !== 1'b0 || dut.r_state !== IDLE || bus_if.rdata_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL fw_after got vld=%b state=%0d rdata=%h exp 0 IDLE deadbeef",
                      bus_if.rdata_valid, dut.r_state, bus_if.rdata_out);
    end
    tick();
  endtask

  task automatic test_flush_req();
    start_load(32'h8000_0050);
    tick();
    bus_if.flush = 1'b1;
    settle();
    total++;
    if (bus_if.data_req !== 1'b1 || bus_if.stall_out !== 1'b0) begin
      bad++; $display("FAIL fr_flush got req=%b stall=%b exp 1/0", bus_if.data_req, bus_if.stall_out);
    end
    tick();
    bus_if.flush  = 1'b0;
    bus_if.mem_en = 1'b0;
    bus_if.data_addr_ok = 1'b1;
    settle();
    total++;
    if (bus_if.data_req !== 1'b1 || bus_if.data_addr !== 32'h8000_0050 || bus_if.stall_out !== 1'b0) begin
      bad++; $display("FAIL fr_held got req=%b addr=%h stall=%b exp 1 80000050 0",
                      bus_if.data_req, bus_if.data_addr, bus_if.stall_out);
    end
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h2222_2222;
    tick();
    idle_inputs();
    settle();
    total++;
    if (bus_if.rdata_valid !== 1'b0 || dut.r_state !== IDLE || bus_if.rdata_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL fr_after got vld=%b state=%0d rdata=%h exp 0 IDLE deadbeef",
                      bus_if.rdata_valid, dut.r_state, bus_if.rdata_out);
    end
    tick();
  endtask

  task automatic test_flush_data_ok();
    start_load(32'h8000_0060);
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h1111_1111;
    bus_if.flush        = 1'b1;
    tick();
    idle_inputs();
    settle();
    total++;
    if (bus_if.rdata_valid !== 1'b0 || dut.r_state !== IDLE || bus_if.rdata_out !== 32'hDEAD_BEEF || dut.r_discard !== 1'b0) begin
      bad++; $display("FAIL fd_same_cycle got vld=%b state=%0d rdata=%h discard=%b exp 0 IDLE deadbeef 0",
                      bus_if.rdata_valid, dut.r_state, bus_if.rdata_out, dut.r_discard);
    end
    tick();
  endtask

  task automatic test_pipe_stall();
    int errs = 0;
    start_load(32'h8000_0020);
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'hCAFE_F00D;
    tick();
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    bus_if.pipe_stall   = 1'b1;  // mem_en stays high: frozen instruction must not reissue
    for (int i = 0; i < 4; i++) begin
      settle();
      if (bus_if.stall_out !== 1'b0 || bus_if.rdata_valid !== 1'b1 || bus_if.rdata_out !== 32'hCAFE_F00D ||
          bus_if.data_req !== 1'b0 || dut.r_state !== DONE) errs++;
      tick();
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL ps_hold got bad_cycles=%0d exp 0 (last stall=%b vld=%b rdata=%h req=%b state=%0d)",
                      errs, bus_if.stall_out, bus_if.rdata_valid, bus_if.rdata_out, bus_if.data_req, dut.r_state);
    end
    bus_if.pipe_stall = 1'b0;
    bus_if.mem_en     = 1'b0;
    settle();
    total++;
    if (dut.r_state !== DONE || bus_if.rdata_valid !== 1'b1) begin
      bad++; $display("FAIL ps_release got state=%0d vld=%b exp DONE 1", dut.r_state, bus_if.rdata_valid);
    end
    tick();
    settle();
    total++;
    if (dut.r_state !== IDLE || bus_if.rdata_valid !== 1'b0 || bus_if.data_req !== 1'b0) begin
      bad++; $display("FAIL ps_idle got state=%0d vld=%b req=%b exp IDLE 0 0", dut.r_state, bus_if.rdata_valid, bus_if.data_req);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_load(32'h8000_0040);
    tick();
    bus_if.mem_en = 1'b0;
    #1;
    total++;
    if (bus_if.data_req !== 1'b1 || dut.r_state !== REQ) begin
      bad++; $display("FAIL rm_in_req got req=%b state=%0d exp 1 REQ", bus_if.data_req, dut.r_state);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.data_req, bus_if.data_wr, bus_if.data_size, bus_if.data_wstrb, bus_if.data_addr,
         bus_if.data_wdata, bus_if.rdata_out, bus_if.rdata_valid, bus_if.stall_out} !== 109'd0 || dut.r_state !== IDLE) begin
      bad++; $display("FAIL rm_async got req=%b addr=%h rdata=%h vld=%b stall=%b state=%0d exp all zero IDLE",
                      bus_if.data_req, bus_if.data_addr, bus_if.rdata_out, bus_if.rdata_valid, bus_if.stall_out, dut.r_state);
    end
    tick();
    settle();
    rst = 1'b0;
    tick();
    start_load(32'h8000_0044);
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    settle();
    total++;
    if (bus_if.rdata_valid !== 1'b1 || bus_if.rdata_out !== 32'h0BAD_F00D || bus_if.stall_out !== 1'b0) begin
      bad++; $display("FAIL rm_reload got vld=%b rdata=%h stall=%b exp 1 0badf00d 0",
                      bus_if.rdata_valid, bus_if.rdata_out, bus_if.stall_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_exception();
    test_flush_wait();
    test_flush_req();
    test_flush_data_ok();
    test_pipe_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
